// File: rtl/serial_pkg.sv
// Shared types and helpers for the framed serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
    function automatic int frame_cycles(input int data_w, input int clks_per_bit, input int parity_en);
        return (2 + data_w + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: pulses bit_end_o on the last cycle of every bit while enabled.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic bit_end_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Held at zero while disabled so every frame starts on a fresh bit period.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_end_o = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [IDX_W-1:0]  idx_q;
    logic              par_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              bit_end;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (busy_q),
        .bit_end_o(bit_end)
    );

    assign shift_d = shift_q >> 1;

    // tx_q is loaded on the same edge as each state change, so the line always matches the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && ready_q) begin
                        state_q <= START;
                        shift_q <= data_i;
                        par_q   <= ^data_i;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_d;
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (PARITY_EN) begin
                                state_q <= PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= IDLE_LEVEL;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            tx_q  <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= IDLE_LEVEL;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        tx_q    <= IDLE_LEVEL;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LEVEL;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o         = tx_q;
    assign ready_o      = ready_q;
    assign busy_o       = busy_q;
    assign frame_done_o = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Three transmitter configurations driven with directed and random traffic, checked against a waveform model.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] valid_drv = '0;
    logic [7:0] data_drv [3];
    logic       chk_en = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Config 0: 8 bits, 4 clk/bit, no parity. Config 1: same with parity. Config 2: 1 bit, 1 clk/bit.
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W = (gi == 2) ? 1 : 8;
        localparam int C = (gi == 2) ? 1 : 4;
        localparam int P = (gi == 1) ? 1 : 0;

        logic [W-1:0] data_w;
        logic         tx, ready, busy, done;
        logic [1:0]   wave_q [$];   // {expected tx level, expected frame_done} per future cycle

        assign data_w = data_drv[gi][W-1:0];

        serial_frame_tx #(
            .DATA_W      (W),
            .CLKS_PER_BIT(C),
            .PARITY_EN   (P[0])
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .data_i      (data_w),
            .valid_i     (valid_drv[gi]),
            .ready_o     (ready),
            .tx_o        (tx),
            .busy_o      (busy),
            .frame_done_o(done)
        );

        // Model: when idle and valid, lay out the whole frame waveform; otherwise consume one cycle.
        always @(posedge clk) begin
            if (reset) begin
                wave_q.delete();
            end else if (wave_q.size() == 0) begin
                if (valid_drv[gi]) begin
                    automatic logic [W-1:0] d = data_w;
                    automatic logic par = 1'b0;
                    automatic int nbits = 2 + W + P;
                    for (int i = 0; i < W; i++) par ^= d[i];
                    for (int b = 0; b < nbits; b++) begin
                        automatic logic lvl;
                        if (b == 0)           lvl = 1'b0;
                        else if (b <= W)      lvl = d[b-1];
                        else if (P == 1 && b == W + 1) lvl = par;
                        else                  lvl = 1'b1;
                        for (int c = 0; c < C; c++)
                            wave_q.push_back({lvl, (b == nbits - 1) && (c == C - 1)});
                    end
                    $display("dut%0d accept data=%0h parity=%0b frame_cycles=%0d",
                             gi, d, par, wave_q.size());
                end
            end else begin
                void'(wave_q.pop_front());
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                automatic bit idle = (wave_q.size() == 0);
                check_eq($sformatf("dut%0d tx", gi),    32'(tx),    idle ? 32'd1 : 32'(wave_q[0][1]));
                check_eq($sformatf("dut%0d ready", gi), 32'(ready), 32'(idle));
                check_eq($sformatf("dut%0d busy", gi),  32'(busy),  32'(!idle));
                check_eq($sformatf("dut%0d done", gi),  32'(done),  idle ? 32'd0 : 32'(wave_q[0][0]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_all(input logic v, input logic [7:0] d);
        valid_drv = {3{v}};
        for (int i = 0; i < 3; i++) data_drv[i] = d;
    endtask

    initial begin
        set_all(1'b0, 8'h00);
        step(2);
        reset = 1'b0;
        chk_en = 1'b1;
        step(10);

        // Single frames: 0xA5, then 0x07 and 0x03 (parity 1 and 0 on the parity config).
        set_all(1'b1, 8'hA5); step(1); set_all(1'b0, 8'h00); step(50);
        set_all(1'b1, 8'h07); step(1); set_all(1'b0, 8'h00); step(50);
        set_all(1'b1, 8'h03); step(1); set_all(1'b0, 8'h00); step(50);

        // valid held high: 0x11 then 0x22, data_i disturbed mid-frame.
        set_all(1'b1, 8'h11); step(10);
        set_all(1'b1, 8'hFF); step(10);
        set_all(1'b1, 8'h22); step(30);
        set_all(1'b0, 8'h00); step(50);

        // Reset during a data bit, with valid high alongside it, then a clean frame.
        set_all(1'b1, 8'hA5); step(1); set_all(1'b0, 8'h00); step(17);
        reset = 1'b1; valid_drv = 3'b111; step(1);
        reset = 1'b0; set_all(1'b0, 8'h00); step(3);
        set_all(1'b1, 8'h5A); step(1); set_all(1'b0, 8'h00); step(50);

        // Random traffic with occasional resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                valid_drv[i] = ($urandom_range(0, 3) != 0);
                data_drv[i]  = 8'($urandom);
            end
            reset = ($urandom_range(0, 149) == 0);
            step(1);
        end
        reset = 1'b0;
        set_all(1'b0, 8'h00);
        step(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
